inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 17 +
 rtl/inst_queue_ram.sv | 32 +++
 rtl/inst_queue.sv | 123 ++++++++++++
 tb/tb_inst_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types and widths for the fetch-to-decode instruction queue.
package inst_queue_pkg;

    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int CAUSE_W = 7;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
        logic               pred_taken;
        logic [PC_W-1:0]    pred_addr;
        logic               exc;
        logic [CAUSE_W-1:0] cause;
    } entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Queue storage: DEPTH entries, two write ports (one pair) and two read ports.
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr1,
    input  logic [AW-1:0] waddr2,
    input  entry_t        wdata1,
    input  entry_t        wdata2,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output entry_t        rdata1,
    output entry_t        rdata2
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr1] <= wdata1;
            mem[waddr2] <= wdata2;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_queue.sv
// Two-wide circular instruction queue between icache fetch and decode.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc1,
    input  logic [PC_W-1:0]          in_pc2,
    input  logic [INST_W-1:0]        in_inst1,
    input  logic [INST_W-1:0]        in_inst2,
    input  logic [1:0]               in_pred_taken,
    input  logic [PC_W-1:0]          in_pred_addr,
    input  logic                     in_exc1,
    input  logic                     in_exc2,
    input  logic [CAUSE_W-1:0]       in_cause1,
    input  logic [CAUSE_W-1:0]       in_cause2,
    output logic                     in_stall,
    input  logic                     get_data_req,
    output logic [1:0]               out_valid,
    output logic [PC_W-1:0]          out_pc1,
    output logic [PC_W-1:0]          out_pc2,
    output logic [INST_W-1:0]        out_inst1,
    output logic [INST_W-1:0]        out_inst2,
    output logic [PC_W-1:0]          out_pred_addr1,
    output logic [PC_W-1:0]          out_pred_addr2,
    output logic [1:0]               out_pred_taken,
    output logic                     out_exc1,
    output logic                     out_exc2,
    output logic [CAUSE_W-1:0]       out_cause1,
    output logic [CAUSE_W-1:0]       out_cause2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic [1:0]    pops;
    logic [CW-1:0] next_count;
    entry_t        wr1;
    entry_t        wr2;
    entry_t        rd1;
    entry_t        rd2;

    // Stall looks only at registered occupancy so fetch never depends on decode.
    assign in_stall = count > CW'(DEPTH - 2);
    assign push     = in_valid && !in_stall;

    always_comb begin
        out_valid = 2'b00;
        if (count >= CW'(2))
            out_valid = 2'b11;
        else if (count == CW'(1))
            out_valid = 2'b01;
    end

    assign pops = get_data_req ? {out_valid[1], out_valid[0] & ~out_valid[1]}
                               : 2'b00;

    assign next_count = count + (push ? CW'(2) : CW'(0)) - CW'(pops);

    assign wr1 = '{pc: in_pc1, inst: in_inst1, pred_taken: in_pred_taken[0],
                   pred_addr: in_pred_addr, exc: in_exc1, cause: in_cause1};
    assign wr2 = '{pc: in_pc2, inst: in_inst2, pred_taken: in_pred_taken[1],
                   pred_addr: in_pred_addr, exc: in_exc2, cause: in_cause2};

    inst_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk    (clk),
        .we     (push && !flush && !rst),
        .waddr1 (tail),
        .waddr2 (tail + AW'(1)),
        .wdata1 (wr1),
        .wdata2 (wr2),
        .raddr1 (head),
        .raddr2 (head + AW'(1)),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + AW'(2);
            head  <= head + AW'(pops);
            count <= next_count;
        end
    end

    // Wrapped subtraction lands above DEPTH, so one bound catches both faults.
    always_ff @(posedge clk) begin
        if (!rst && !flush)
            assert (next_count <= CW'(DEPTH))
            else $error("inst_queue occupancy out of range: %0d", next_count);
    end

    assign out_pc1        = out_valid[0] ? rd1.pc        : '0;
    assign out_inst1      = out_valid[0] ? rd1.inst      : '0;
    assign out_pred_addr1 = out_valid[0] ? rd1.pred_addr : '0;
    assign out_exc1       = out_valid[0] ? rd1.exc       : 1'b0;
    assign out_cause1     = out_valid[0] ? rd1.cause     : '0;
    assign out_pc2        = out_valid[1] ? rd2.pc        : '0;
    assign out_inst2      = out_valid[1] ? rd2.inst      : '0;
    assign out_pred_addr2 = out_valid[1] ? rd2.pred_addr : '0;
    assign out_exc2       = out_valid[1] ? rd2.exc       : 1'b0;
    assign out_cause2     = out_valid[1] ? rd2.cause     : '0;
    assign out_pred_taken = {out_valid[1] & rd2.pred_taken,
                             out_valid[0] & rd1.pred_taken};

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a scoreboard of expected queue entries.
module tb_inst_queue;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pa;
        logic        pt;
        logic        exc;
        logic [6:0]  cause;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc1 = '0, in_pc2 = '0;
    logic [31:0] in_inst1 = '0, in_inst2 = '0;
    logic [1:0]  in_pred_taken = '0;
    logic [31:0] in_pred_addr = '0;
    logic        in_exc1 = 1'b0, in_exc2 = 1'b0;
    logic [6:0]  in_cause1 = '0, in_cause2 = '0;
    logic        in_stall;
    logic        get_data_req = 1'b0;
    logic [1:0]  out_valid;
    logic [31:0] out_pc1, out_pc2, out_inst1, out_inst2;
    logic [31:0] out_pred_addr1, out_pred_addr2;
    logic [1:0]  out_pred_taken;
    logic        out_exc1, out_exc2;
    logic [6:0]  out_cause1, out_cause2;
    logic [3:0]  count;

    int   compared = 0;
    int   mismatched = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_pc1(in_pc1), .in_pc2(in_pc2),
        .in_inst1(in_inst1), .in_inst2(in_inst2),
        .in_pred_taken(in_pred_taken), .in_pred_addr(in_pred_addr),
        .in_exc1(in_exc1), .in_exc2(in_exc2),
        .in_cause1(in_cause1), .in_cause2(in_cause2),
        .in_stall(in_stall), .get_data_req(get_data_req),
        .out_valid(out_valid),
        .out_pc1(out_pc1), .out_pc2(out_pc2),
        .out_inst1(out_inst1), .out_inst2(out_inst2),
        .out_pred_addr1(out_pred_addr1), .out_pred_addr2(out_pred_addr2),
        .out_pred_taken(out_pred_taken),
        .out_exc1(out_exc1), .out_exc2(out_exc2),
        .out_cause1(out_cause1), .out_cause2(out_cause2),
        .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the visible head/head+1 entries against the scoreboard front.
    task automatic check_outputs();
        int   n;
        ent_t e1, e2, z;
        n = sb.size();
        z = '{pc: '0, inst: '0, pa: '0, pt: 1'b0, exc: 1'b0, cause: '0};
        e1 = (n >= 1) ? sb[0] : z;
        e2 = (n >= 2) ? sb[1] : z;
        chk("count", 32'(count), 32'(n));
        chk("in_stall", 32'(in_stall), 32'(n > DEPTH - 2));
        chk("out_valid", 32'(out_valid),
            (n >= 2) ? 32'd3 : (n == 1) ? 32'd1 : 32'd0);
        chk("out_pc1", out_pc1, e1.pc);
        chk("out_pc2", out_pc2, e2.pc);
        chk("out_inst1", out_inst1, e1.inst);
        chk("out_inst2", out_inst2, e2.inst);
        chk("out_pred_addr1", out_pred_addr1, e1.pa);
        chk("out_pred_addr2", out_pred_addr2, e2.pa);
        chk("out_pred_taken", 32'(out_pred_taken), 32'({e2.pt, e1.pt}));
        chk("out_exc", 32'({out_exc2, out_exc1}), 32'({e2.exc, e1.exc}));
        chk("out_cause1", 32'(out_cause1), 32'(e1.cause));
        chk("out_cause2", 32'(out_cause2), 32'(e2.cause));
    endtask

    task automatic step(input logic v, input logic [31:0] pc,
                        input logic [1:0] pt, input logic e2,
                        input logic [6:0] c2, input logic req,
                        input logic fl);
        int  n;
        bit  acc;
        in_valid      = v;
        in_pc1        = pc;
        in_pc2        = pc + 32'd4;
        in_inst1      = $urandom;
        in_inst2      = $urandom;
        in_pred_taken = pt;
        in_pred_addr  = pc + 32'h100;
        in_exc1       = 1'b0;
        in_exc2       = e2;
        in_cause1     = '0;
        in_cause2     = c2;
        get_data_req  = req;
        flush         = fl;
        #1;
        check_outputs();
        n   = sb.size();
        acc = v && (n <= DEPTH - 2);
        if (fl) begin
            sb.delete();
        end else begin
            if (req) begin
                if (n >= 1) void'(sb.pop_front());
                if (n >= 2) void'(sb.pop_front());
            end
            if (acc) begin
                sb.push_back('{pc: in_pc1, inst: in_inst1, pa: in_pred_addr,
                               pt: pt[0], exc: 1'b0, cause: 7'd0});
                sb.push_back('{pc: in_pc2, inst: in_inst2, pa: in_pred_addr,
                               pt: pt[1], exc: e2, cause: c2});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc);
        step(1'b1, pc, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 32'd0, 2'b00, 1'b0, 7'd0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();

        // Reset state
        idle();

        // Two pairs with no decode requests
        push(32'h1c00_0000);
        push(32'h1c00_0008);
        idle();
        chk("fill4_count", 32'(count), 32'd4);
        chk("fill4_pc1", out_pc1, 32'h1c00_0000);
        chk("fill4_pc2", out_pc2, 32'h1c00_0004);

        // Fill to the stall point; a further pair must be dropped
        push(32'h1c00_0010);
        push(32'h1c00_0018);
        idle();
        chk("full_stall", 32'(in_stall), 32'd1);
        push(32'h1c00_0020);
        chk("dropped_count", 32'(count), 32'd8);
        idle();

        repeat (4) pop();
        idle();

        // Streaming push/pop; pointers wrap several times
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'h2000_0000 + 32'(i * 8), 2'(i), 1'b0, 7'd0,
                 (i > 0), 1'b0);
        for (int i = 0; i < 24; i++)
            step(1'($urandom), 32'h3000_0000 + 32'(i * 8), 2'($urandom),
                 1'($urandom), 7'($urandom), 1'($urandom), 1'b0);
        repeat (5) pop();
        idle();

        // Flush beats a simultaneous push and pop
        push(32'h4000_0000);
        push(32'h4000_0008);
        push(32'h4000_0010);
        chk("preflush_count", 32'(count), 32'd6);
        step(1'b1, 32'h4000_0018, 2'b00, 1'b0, 7'd0, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_stall", 32'(in_stall), 32'd0);
        idle();

        // Exception and prediction on slot 2 only
        step(1'b1, 32'h5000_0000, 2'b10, 1'b1, 7'h08, 1'b0, 1'b0);
        chk("exc_exc2", 32'(out_exc2), 32'd1);
        chk("exc_cause2", 32'(out_cause2), 32'h08);
        chk("exc_pt", 32'(out_pred_taken), 32'b10);
        chk("exc_slot1", 32'({out_exc1, out_cause1}), 32'd0);
        idle();

        // Reset mid-operation beats flush, push and pop
        push(32'h6000_0000);
        rst          = 1'b1;
        in_valid     = 1'b1;
        get_data_req = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        idle();
        push(32'h7000_0000);
        idle();
        pop();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
